parallel_bus_controller: RTL and testbench
==========================================

# parallel_bus_controller

Sequencer for the 8-bit bidirectional host (Raspberry Pi) parallel link. It sits between the parallel transceiver and the FPGA fabric, and owns the transceiver's direction control (`bus_dir`, wired to the transceiver `chip_select`). It synchronises the host's `host_cs` and `host_strobe`, enforces bus turnaround, and buffers bytes in each direction through FIFOs exposed as valid/ready streams.

## Interface
- `FIFO_DEPTH`, 16: entries per direction; power of two, ≥ 2.
- `SYNC_STAGES`, 2: flops in each input synchroniser; ≥ 2.
- `TURNAROUND`, 2: idle clock cycles in each turnaround state; ≥ 1.
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `host_cs`  in  1  asynchronous; 1 = host writes to FPGA, 0 = host reads from FPGA.
- `host_strobe`  in  1  asynchronous; each rising edge transfers one byte.
- `host_ready`  out  1  to host; meaning depends on direction (see Operation).
- `bus_dir`  out  1  to transceiver `chip_select`; 1 = FPGA receives (pins tri-stated), 0 = FPGA drives.
- `bus_rx_data`  in  8  byte captured by the transceiver.
- `bus_tx_data`  out  8  byte for the transceiver to drive.
- `rx_valid`, `rx_data[7:0]`  out, `rx_ready`  in  fabric receive stream.
- `tx_valid`, `tx_data[7:0]`  in, `tx_ready`  out  fabric transmit stream.
- `err`  out  3  sticky error flags: [0] overrun, [1] underrun, [2] protocol.
- `err_clear`  in  1  clears all `err` bits; a new error in the same cycle wins.

## Operation
- Input synchronisers:
  - `host_cs` and `host_strobe` each pass through `SYNC_STAGES` flops.
  - A rising-edge detector on the synchronised strobe produces `stb`, a one-cycle pulse.
- State machine states: `RX_IDLE`, `TURN_TX`, `TX_IDLE`, `TURN_RX`.
- `RX_IDLE`:
  - `bus_dir` = 1; `host_ready` = !rx_full.
  - On `stb`: push `bus_rx_data` if RX FIFO not full. Otherwise drop the byte and set `err[0]`.
  - If synchronised `host_cs` = 0, go to `TURN_TX`.
- `TURN_TX`:
  - `bus_dir` = 1; `host_ready` = 0.
  - Count `TURNAROUND` cycles, then go to `TX_IDLE`.
- `TX_IDLE`:
  - `bus_dir` = 0; `host_ready` = !tx_empty.
  - `bus_tx_data` is registered and holds the TX FIFO head, or 0x00 when the FIFO is empty.
  - On `stb`: pop if the FIFO is not empty. Otherwise set `err[1]`.
  - If synchronised `host_cs` = 1: `bus_dir` goes to 1 in the next cycle and the state goes to `TURN_RX`. This check takes priority over `stb` in the same cycle.
- `TURN_RX`:
  - `bus_dir` = 1; `host_ready` = 0.
  - Count `TURNAROUND` cycles, then go to `RX_IDLE`.
- Any `stb` in either TURN state is ignored and sets `err[2]`.
- A `host_cs` change during a TURN state is re-evaluated only on entering the next IDLE state.
- Fabric streams:
  - `rx_valid` = !rx_empty; `rx_data` = RX head; pop on `rx_valid & rx_ready`.
  - `tx_ready` = !tx_full; push on `tx_valid & tx_ready`.
- FIFO full/empty rules:
  - Evaluated on occupancy at the start of the cycle.
  - A bus push into a full RX FIFO is rejected even if the fabric pops in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers are log2(`FIFO_DEPTH`) bits and wrap modulo `FIFO_DEPTH`. Count is log2(`FIFO_DEPTH`)+1 bits.
- Host obligations:
  - Hold `host_cs` stable while `host_ready` = 0.
  - Keep strobes at least `SYNC_STAGES`+2 cycles high and low.
  - Set data at least 2 clocks before raising the strobe.

## Timing
- Reset values:
  - State `RX_IDLE`, `bus_dir` = 1, `host_ready` = 1.
  - `bus_tx_data` = 0x00, `rx_valid` = 0, `tx_ready` = 1, `err` = 0.
  - FIFOs empty; turnaround counter 0.
- Reset mid-transfer: both FIFOs are flushed and the bus is released (`bus_dir` = 1) in the cycle after `reset` is sampled.
- Strobe latency: `stb` fires `SYNC_STAGES`+1 cycles after the first clock that samples `host_strobe` high. `rx_valid` rises 1 cycle after `stb`, i.e. 4 cycles at defaults.
- TX pop: `bus_tx_data` shows the next byte 1 cycle after `stb`.
- Direction change host write → host read: `host_cs` falls; `bus_dir` goes to 0 after `SYNC_STAGES`+1+`TURNAROUND` cycles.
- Direction change host read → host write: `bus_dir` goes to 1 within `SYNC_STAGES`+1 cycles of `host_cs` rising.

## Structure
- Package `parallel_bus_pkg` holds:
  - the state enum;
  - the `err` bit indices (`ERR_OVERRUN`, `ERR_UNDERRUN`, `ERR_PROTO`);
  - the byte width constant 8.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; push/pop/full/empty/count), instantiated once for RX and once for TX.
- Synchronisers, edge detector and FSM are inline in `parallel_bus_controller`.

## Test plan
- Host writes 0xA5, 0x3C with `rx_ready`=1 → `rx_data` shows 0xA5 then 0x3C in order; first `rx_valid` 4 cycles after the strobe is sampled; `err`=0.
- `rx_ready`=0, host writes 17 bytes (0x00–0x10) → `host_ready` falls after the 16th; byte 0x10 is dropped and `err[0]`=1; draining returns 0x00–0x0F.
- Fabric pushes 0x11, 0x22, then `host_cs` falls → `bus_dir` goes to 0 after 5 cycles with `bus_tx_data`=0x11; one strobe gives 0x22; a third strobe sets `err[1]` and `bus_tx_data` becomes 0x00.
- Strobe pulsed during `TURN_TX` → ignored, `err[2]`=1, RX FIFO unchanged; then `err_clear` → `err`=0.
- `reset` asserted while in `TX_IDLE` with 3 TX bytes queued → next cycle `bus_dir`=1, `tx_ready`=1, FIFOs empty, state `RX_IDLE`.
- Simultaneous `rx_ready` pop and bus push while the RX FIFO is full → push rejected, `err[0]`=1, count becomes `FIFO_DEPTH`−1.

Source files
------------

// File: rtl/parallel_bus_pkg.sv
// parallel_bus_pkg: shared types and constants for the host parallel link
package parallel_bus_pkg;
    localparam int BYTE_W       = 8;
    localparam int ERR_OVERRUN  = 0;
    localparam int ERR_UNDERRUN = 1;
    localparam int ERR_PROTO    = 2;
    typedef enum logic [1:0] {RX_IDLE, TURN_TX, TX_IDLE, TURN_RX} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO whose registered head shows the oldest entry, or zero when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    logic [AW:0] left;
    always_comb begin
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        left    = count - (AW+1)'(do_pop);
    end
    always_ff @(posedge clock)
        if (do_push)
            mem[wr_ptr] <= din;
    // head is precomputed for after this edge so consumers see a pop on the very next cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            head   <= left == '0 ? (do_push ? din : '0) : mem[rd_ptr + AW'(do_pop)];
        end
    end
endmodule

// File: rtl/parallel_bus_controller.sv
// parallel_bus_controller: host parallel-link sequencer with bus turnaround and per-direction FIFOs
module parallel_bus_controller
    import parallel_bus_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_cs,
    input  logic              host_strobe,
    output logic              host_ready,
    output logic              bus_dir,
    input  logic [BYTE_W-1:0] bus_rx_data,
    output logic [BYTE_W-1:0] bus_tx_data,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_data,
    input  logic              rx_ready,
    input  logic              tx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_ready,
    output logic [2:0]        err,
    input  logic              err_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TURNAROUND + 1);
    state_t state, state_nxt;
    logic [TW-1:0] turn_cnt;
    logic [SYNC_STAGES-1:0] cs_sync, stb_sync;
    logic cs_s, stb_prev, stb, in_turn, turn_done;
    logic rx_push, tx_pop, rx_full, rx_empty, tx_full, tx_empty;
    logic [AW:0] rx_count, tx_count;
    logic [2:0] err_new;

    assign cs_s = cs_sync[SYNC_STAGES-1];

    // cs resets to "host writes" so the link comes up receiving
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync  <= '1;
            stb_sync <= '0;
            stb_prev <= 1'b0;
            stb      <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], host_cs};
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], host_strobe};
            stb_prev <= stb_sync[SYNC_STAGES-1];
            stb      <= stb_sync[SYNC_STAGES-1] && !stb_prev;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RX_IDLE;
            turn_cnt <= '0;
        end else begin
            state    <= state_nxt;
            turn_cnt <= (in_turn && !turn_done) ? turn_cnt + TW'(1) : '0;
        end
    end

    always_comb begin
        in_turn   = state == TURN_TX || state == TURN_RX;
        turn_done = turn_cnt == TW'(TURNAROUND - 1);
        state_nxt = state;
        case (state)
            RX_IDLE: state_nxt = cs_s ? RX_IDLE : TURN_TX;
            TURN_TX: state_nxt = turn_done ? TX_IDLE : TURN_TX;
            TX_IDLE: state_nxt = cs_s ? TURN_RX : TX_IDLE;
            default: state_nxt = turn_done ? RX_IDLE : TURN_RX;
        endcase
    end

    // a direction change in TX_IDLE swallows a coincident strobe
    always_comb begin
        bus_dir    = state != TX_IDLE;
        host_ready = state == RX_IDLE ? !rx_full : state == TX_IDLE ? !tx_empty : 1'b0;
        rx_push    = stb && state == RX_IDLE;
        tx_pop     = stb && state == TX_IDLE && !cs_s;
        rx_valid   = !rx_empty;
        tx_ready   = !tx_full;
        err_new    = '0;
        err_new[ERR_OVERRUN]  = rx_push && rx_count == (AW+1)'(FIFO_DEPTH);
        err_new[ERR_UNDERRUN] = tx_pop && tx_count == '0;
        err_new[ERR_PROTO]    = stb && in_turn;
    end

    always_ff @(posedge clock) begin
        if (reset)
            err <= '0;
        else
            err <= (err_clear ? 3'b000 : err) | err_new;
    end

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .din   (bus_rx_data),
        .pop   (rx_ready),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_data)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clock (clock),
        .reset (reset),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (bus_tx_data)
    );
endmodule

// File: tb/tb_parallel_bus_controller.sv
// tb_parallel_bus_controller: table-driven and sequence checks of the host parallel-link controller
module tb_parallel_bus_controller;
    import parallel_bus_pkg::*;
    logic clock = 1'b0;
    logic reset, host_cs, host_strobe, host_ready, bus_dir;
    logic rx_valid, rx_ready, tx_valid, tx_ready, err_clear;
    logic [7:0] bus_rx_data, bus_tx_data, rx_data, tx_data;
    logic [2:0] err;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic cs, stb;
        logic [7:0] rxd;
        logic rxr, txv;
        logic [7:0] txd;
        logic clr;
        int n;
        logic hr, dir, rv;
        logic [7:0] rd, txb;
        logic [2:0] e;
    } vec_t;
    vec_t tbl[$];

    parallel_bus_controller dut (
        .clock       (clock),
        .reset       (reset),
        .host_cs     (host_cs),
        .host_strobe (host_strobe),
        .host_ready  (host_ready),
        .bus_dir     (bus_dir),
        .bus_rx_data (bus_rx_data),
        .bus_tx_data (bus_tx_data),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .err         (err),
        .err_clear   (err_clear)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic cs, input logic stb, input logic [7:0] rxd, input logic rxr,
                       input logic txv, input logic [7:0] txd, input logic clr, input int n,
                       input logic hr, input logic dir, input logic rv, input logic [7:0] rd,
                       input logic [7:0] txb, input logic [2:0] e);
        vec_t v;
        v.cs = cs; v.stb = stb; v.rxd = rxd; v.rxr = rxr; v.txv = txv; v.txd = txd; v.clr = clr;
        v.n = n; v.hr = hr; v.dir = dir; v.rv = rv; v.rd = rd; v.txb = txb; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus_rx_data = b;
        tick(2);
        host_strobe = 1'b1;
        tick(4);
        host_strobe = 1'b0;
        tick(4);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; host_cs = 1'b1; host_strobe = 1'b0; bus_rx_data = 8'h00;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clear = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("reset host_ready", 32'(host_ready), 32'd1);
        chk("reset bus_dir", 32'(bus_dir), 32'd1);
        chk("reset bus_tx_data", 32'(bus_tx_data), 32'h00);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset tx_ready", 32'(tx_ready), 32'd1);
        chk("reset err", 32'(err), 32'd0);

        //   cs stb rxd    rxr txv txd    clr n   hr dir rv rd     txb    err
        add(1, 0, 8'hA5, 0, 0, 8'h00, 0, 2,  1, 1, 0, 8'h00, 8'h00, 3'b000);
        add(1, 1, 8'hA5, 0, 0, 8'h00, 0, 3,  1, 1, 0, 8'h00, 8'h00, 3'b000);
        add(1, 1, 8'hA5, 0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hA5, 8'h00, 3'b000);
        add(1, 0, 8'h3C, 0, 0, 8'h00, 0, 4,  1, 1, 1, 8'hA5, 8'h00, 3'b000);
        add(1, 1, 8'h3C, 0, 0, 8'h00, 0, 4,  1, 1, 1, 8'hA5, 8'h00, 3'b000);
        add(1, 0, 8'h3C, 1, 0, 8'h00, 0, 1,  1, 1, 1, 8'h3C, 8'h00, 3'b000);
        add(1, 0, 8'h3C, 1, 0, 8'h00, 0, 1,  1, 1, 0, 8'h00, 8'h00, 3'b000);
        add(1, 0, 8'h00, 0, 1, 8'h11, 0, 1,  1, 1, 0, 8'h00, 8'h11, 3'b000);
        add(1, 0, 8'h00, 0, 1, 8'h22, 0, 1,  1, 1, 0, 8'h00, 8'h11, 3'b000);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 4,  0, 1, 0, 8'h00, 8'h11, 3'b000);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 8'h11, 3'b000);
        add(0, 1, 8'h00, 0, 0, 8'h00, 0, 4,  1, 0, 0, 8'h00, 8'h22, 3'b000);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 4,  1, 0, 0, 8'h00, 8'h22, 3'b000);
        add(0, 1, 8'h00, 0, 0, 8'h00, 0, 4,  0, 0, 0, 8'h00, 8'h00, 3'b000);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 4,  0, 0, 0, 8'h00, 8'h00, 3'b000);
        add(0, 1, 8'h00, 0, 0, 8'h00, 0, 4,  0, 0, 0, 8'h00, 8'h00, 3'b010);
        add(0, 0, 8'h00, 0, 0, 8'h00, 1, 1,  0, 0, 0, 8'h00, 8'h00, 3'b000);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 2,  0, 0, 0, 8'h00, 8'h00, 3'b000);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 1, 0, 8'h00, 8'h00, 3'b000);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 2,  1, 1, 0, 8'h00, 8'h00, 3'b000);
        add(0, 1, 8'h55, 0, 0, 8'h00, 0, 4,  0, 1, 0, 8'h00, 8'h00, 3'b100);
        add(0, 0, 8'h55, 0, 0, 8'h00, 1, 1,  0, 0, 0, 8'h00, 8'h00, 3'b000);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 3,  0, 1, 0, 8'h00, 8'h00, 3'b000);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 2,  1, 1, 0, 8'h00, 8'h00, 3'b000);

        foreach (tbl[i]) begin
            host_cs = tbl[i].cs; host_strobe = tbl[i].stb; bus_rx_data = tbl[i].rxd;
            rx_ready = tbl[i].rxr; tx_valid = tbl[i].txv; tx_data = tbl[i].txd; err_clear = tbl[i].clr;
            tick(tbl[i].n);
            chk($sformatf("row%0d host_ready", i), 32'(host_ready), 32'(tbl[i].hr));
            chk($sformatf("row%0d bus_dir", i), 32'(bus_dir), 32'(tbl[i].dir));
            chk($sformatf("row%0d rx_valid", i), 32'(rx_valid), 32'(tbl[i].rv));
            chk($sformatf("row%0d rx_data", i), 32'(rx_data), 32'(tbl[i].rd));
            chk($sformatf("row%0d bus_tx_data", i), 32'(bus_tx_data), 32'(tbl[i].txb));
            chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].e));
        end
        err_clear = 1'b0;
        rx_ready = 1'b0;

        for (int i = 0; i < 16; i++) write_byte(8'(i));
        chk("ovf host_ready after 16", 32'(host_ready), 32'd0);
        chk("ovf err after 16", 32'(err), 32'd0);
        write_byte(8'h10);
        chk("ovf err after 17", 32'(err), 32'b001);
        chk("ovf rx_valid", 32'(rx_valid), 32'd1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain %0d", i), 32'(rx_data), 32'(i));
            tick(1);
        end
        rx_ready = 1'b0;
        chk("drain empty", 32'(rx_valid), 32'd0);

        for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
        bus_rx_data = 8'h99;
        tick(2);
        host_strobe = 1'b1;
        tick(3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("simul err", 32'(err), 32'b001);
        chk("simul count", 32'(dut.u_rx.count), 32'd15);
        chk("simul rx_data", 32'(rx_data), 32'h41);
        chk("simul host_ready", 32'(host_ready), 32'd1);
        host_strobe = 1'b0;
        err_clear = 1'b1;
        tick(4);
        err_clear = 1'b0;

        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'(8'h70 + i);
            tick(1);
        end
        tx_valid = 1'b0;
        host_cs = 1'b0;
        tick(5);
        chk("pre-reset bus_dir", 32'(bus_dir), 32'd0);
        chk("pre-reset bus_tx_data", 32'(bus_tx_data), 32'h70);
        reset = 1'b1;
        host_cs = 1'b1;
        tick(1);
        chk("mid reset bus_dir", 32'(bus_dir), 32'd1);
        chk("mid reset tx_ready", 32'(tx_ready), 32'd1);
        chk("mid reset bus_tx_data", 32'(bus_tx_data), 32'h00);
        chk("mid reset rx_valid", 32'(rx_valid), 32'd0);
        chk("mid reset state", 32'(dut.state), 32'(RX_IDLE));
        chk("mid reset tx count", 32'(dut.u_tx.count), 32'd0);
        chk("mid reset rx count", 32'(dut.u_rx.count), 32'd0);
        chk("mid reset host_ready", 32'(host_ready), 32'd1);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
